pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 72 +++++++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline types and defaults for the hazard controller.
// Holds the FSM encoding, control bundle and default sizing.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } hz_state_e;

  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF   = 16;
  localparam int WAIT_W      = 8;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic memwb_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN = '{
    pc_write:    1'b1,
    ifid_write:  1'b1,
    ifid_flush:  1'b0,
    idex_write:  1'b1,
    idex_flush:  1'b0,
    exmem_write: 1'b1,
    memwb_flush: 1'b0
  };

  localparam hz_ctrl_t CTRL_MEM = '{
    pc_write:    1'b0,
    ifid_write:  1'b0,
    ifid_flush:  1'b0,
    idex_write:  1'b0,
    idex_flush:  1'b0,
    exmem_write: 1'b0,
    memwb_flush: 1'b1
  };

  localparam hz_ctrl_t CTRL_BR = '{
    pc_write:    1'b1,
    ifid_write:  1'b1,
    ifid_flush:  1'b1,
    idex_write:  1'b1,
    idex_flush:  1'b1,
    exmem_write: 1'b1,
    memwb_flush: 1'b0
  };

  localparam hz_ctrl_t CTRL_LU = '{
    pc_write:    1'b0,
    ifid_write:  1'b0,
    ifid_flush:  1'b0,
    idex_write:  1'b1,
    idex_flush:  1'b1,
    exmem_write: 1'b1,
    memwb_flush: 1'b0
  };

  function automatic logic src_hit(
    input logic       used,
    input logic [4:0] rs,
    input logic [4:0] rd
  );
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Holds at all-ones; synchronous active-high reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush decode, memory-wait FSM,
// sticky memory timeout and saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memtoreg,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);

  logic              mem_stall;
  logic              rs1_hit;
  logic              rs2_hit;
  logic              load_use;
  logic              sel_mem;
  logic              sel_br;
  logic              sel_lu;
  hz_ctrl_t          ctrl;
  hz_state_e         state_q;
  hz_state_e         state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic              timeout_q;
  logic              timeout_d;
  logic              timeout_hit;
  logic              stall_inc;
  logic              flush_inc;

  assign mem_stall = mem_req & ~mem_ready;
  assign rs1_hit   = src_hit(id_uses_rs1, id_rs1, ex_rd);
  assign rs2_hit   = src_hit(id_uses_rs2, id_rs2, ex_rd);
  assign load_use  = ex_memtoreg & (ex_rd != 5'd0)
                   & (rs1_hit | rs2_hit);

  // Selects are made mutually exclusive so the decode is one-hot.
  assign sel_mem = mem_stall;
  assign sel_br  = ~mem_stall & ex_branch_taken;
  assign sel_lu  = ~mem_stall & ~ex_branch_taken & load_use;

  always_comb begin
    ctrl = CTRL_RUN;
    unique case (1'b1)
      sel_mem: ctrl = CTRL_MEM;
      sel_br:  ctrl = CTRL_BR;
      sel_lu:  ctrl = CTRL_LU;
      default: ctrl = CTRL_RUN;
    endcase
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_write  = ctrl.idex_write;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_write = ctrl.exmem_write;
  assign memwb_flush = ctrl.memwb_flush;

  // wait_q counts stall cycles already spent in the current wait,
  // including the RUN cycle that entered MEMWAIT; it is 0 in RUN.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEMWAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          wait_d  = '0;
        end
      end
      MEMWAIT: begin
        if (!mem_stall) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q != '1) begin
          wait_d  = wait_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  assign timeout_hit = mem_stall & (wait_q == TIMEOUT_W);
  assign timeout_d   = timeout_q | timeout_hit;
  assign mem_timeout = timeout_q | timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_inc = ~ctrl.pc_write;
  assign flush_inc = ctrl.ifid_flush | ctrl.idex_flush;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: default-sized DUT plus a small one
// (TIMEOUT=4, CNT_W=2) for timeout and saturation cases.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  // {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f}
  localparam logic [6:0] C_RUN = 7'b1101010;
  localparam logic [6:0] C_MEM = 7'b0000001;
  localparam logic [6:0] C_BR  = 7'b1111110;
  localparam logic [6:0] C_LU  = 7'b0001110;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2;
  logic       ex_memtoreg, ex_branch_taken;
  logic       mem_req, mem_ready;

  logic        pc_write, ifid_write, ifid_flush, idex_write;
  logic        idex_flush, exmem_write, memwb_flush, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;
  logic        pc_write_s, ifid_write_s, ifid_flush_s, idex_write_s;
  logic        idex_flush_s, exmem_write_s, memwb_flush_s;
  logic        mem_timeout_s;
  logic [1:0]  stall_cnt_s, flush_cnt_s;
  logic [6:0]  ctl, ctl_s;

  int checks = 0;
  int errors = 0;

  assign ctl = {pc_write, ifid_write, ifid_flush, idex_write,
                idex_flush, exmem_write, memwb_flush};
  assign ctl_s = {pc_write_s, ifid_write_s, ifid_flush_s,
                  idex_write_s, idex_flush_s, exmem_write_s,
                  memwb_flush_s};

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memtoreg(ex_memtoreg),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_write(idex_write),
    .idex_flush(idex_flush), .exmem_write(exmem_write),
    .memwb_flush(memwb_flush), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memtoreg(ex_memtoreg),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write_s), .ifid_write(ifid_write_s),
    .ifid_flush(ifid_flush_s), .idex_write(idex_write_s),
    .idex_flush(idex_flush_s), .exmem_write(exmem_write_s),
    .memwb_flush(memwb_flush_s), .mem_timeout(mem_timeout_s),
    .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
  );

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_memtoreg = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic lu5();
    ex_memtoreg = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); idle(); reset = 1'b1; #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++; $display("FAIL rst_ctl_idle: got %b want %b", ctl, C_RUN);
    end
    lu5(); #1;
    checks++;
    if (ctl !== C_LU) begin
      errors++; $display("FAIL rst_ctl_lu: got %b want %b", ctl, C_LU);
    end
    @(negedge clk); idle(); reset = 1'b0; #1;
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    checks++;
    if (mem_timeout !== 1'b0 || mem_timeout_s !== 1'b0) begin
      errors++;
      $display("FAIL rst_timeout: got %b/%b want 0/0",
               mem_timeout, mem_timeout_s);
    end
    checks++;
    if (dut.state_q !== RUN) begin
      errors++; $display("FAIL rst_state: got %b want RUN", dut.state_q);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk); lu5(); #1;
    checks++;
    if (ctl !== C_LU) begin
      errors++; $display("FAIL lu_ctl: got %b want %b", ctl, C_LU);
    end
    @(negedge clk); idle(); #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++; $display("FAIL lu_after: got %b want %b", ctl, C_RUN);
    end
    checks++;
    if (stall_cnt !== 16'd1 || flush_cnt !== 16'd1) begin
      errors++;
      $display("FAIL lu_cnt: got %0d/%0d want 1/1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_x0();
    do_reset();
    @(negedge clk); lu5(); ex_rd = 5'd0; id_rs1 = 5'd0; #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++; $display("FAIL x0_ctl: got %b want %b", ctl, C_RUN);
    end
    lu5(); id_uses_rs1 = 1'b0; #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++; $display("FAIL unused_src: got %b want %b", ctl, C_RUN);
    end
    @(negedge clk); idle(); #1;
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL x0_cnt: got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_branch();
    do_reset();
    @(negedge clk); lu5(); ex_branch_taken = 1'b1; #1;
    checks++;
    if (ctl !== C_BR) begin
      errors++; $display("FAIL br_ctl: got %b want %b", ctl, C_BR);
    end
    @(negedge clk); idle(); #1;
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL br_cnt: got %0d/%0d want 1/0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); idle(); mem_req = 1'b1; #1;
      checks++;
      if (ctl !== C_MEM) begin
        errors++;
        $display("FAIL mw_ctl c%0d: got %b want %b", i, ctl, C_MEM);
      end
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++; $display("FAIL mw_ready: got %b want %b", ctl, C_RUN);
    end
    checks++;
    if (stall_cnt !== 16'd3 || stall_cnt_s !== 2'd3) begin
      errors++;
      $display("FAIL mw_cnt: got %0d/%0d want 3/3",
               stall_cnt, stall_cnt_s);
    end
    @(negedge clk); idle(); #1;
    checks++;
    if (stall_cnt !== 16'd3 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mw_cnt2: got %0d/%0d want 3/0",
               stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_memwait_hazard();
    do_reset();
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk); lu5(); ex_branch_taken = 1'b1;
      mem_req = 1'b1; mem_ready = 1'b0; #1;
      checks++;
      if (ctl !== C_MEM) begin
        errors++;
        $display("FAIL mwh_frozen c%0d: got %b want %b", i, ctl, C_MEM);
      end
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    checks++;
    if (ctl !== C_BR) begin
      errors++; $display("FAIL mwh_br: got %b want %b", ctl, C_BR);
    end
    @(negedge clk); idle(); #1;
    checks++;
    if (stall_cnt !== 16'd2 || flush_cnt !== 16'd1) begin
      errors++;
      $display("FAIL mwh_cnt: got %0d/%0d want 2/1",
               stall_cnt, flush_cnt);
    end
    @(negedge clk); lu5(); mem_req = 1'b1; #1;
    @(negedge clk); mem_ready = 1'b1; #1;
    checks++;
    if (ctl !== C_LU) begin
      errors++; $display("FAIL mwh_lu: got %b want %b", ctl, C_LU);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk); idle(); mem_req = 1'b1; #1;
      checks++;
      if (mem_timeout_s !== (i >= 5)) begin
        errors++;
        $display("FAIL to_rise c%0d: got %b want %b",
                 i, mem_timeout_s, (i >= 5));
      end
    end
    checks++;
    if (mem_timeout !== 1'b0) begin
      errors++; $display("FAIL to_default: got %b want 0", mem_timeout);
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    checks++;
    if (mem_timeout_s !== 1'b1 || ctl_s !== C_RUN) begin
      errors++;
      $display("FAIL to_ready: got %b/%b want 1/%b",
               mem_timeout_s, ctl_s, C_RUN);
    end
    checks++;
    if (stall_cnt !== 16'd6 || stall_cnt_s !== 2'd3) begin
      errors++;
      $display("FAIL to_cnt: got %0d/%0d want 6/3",
               stall_cnt, stall_cnt_s);
    end
    repeat (2) @(negedge clk);
    idle(); #1;
    checks++;
    if (mem_timeout_s !== 1'b1) begin
      errors++; $display("FAIL to_sticky: got %b want 1", mem_timeout_s);
    end
    do_reset(); #1;
    checks++;
    if (mem_timeout_s !== 1'b0) begin
      errors++; $display("FAIL to_clear: got %b want 0", mem_timeout_s);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (5) begin
      @(negedge clk); lu5();
    end
    @(negedge clk); idle(); #1;
    checks++;
    if (stall_cnt_s !== 2'd3 || flush_cnt_s !== 2'd3) begin
      errors++;
      $display("FAIL sat_small: got %0d/%0d want 3/3",
               stall_cnt_s, flush_cnt_s);
    end
    checks++;
    if (stall_cnt !== 16'd5 || flush_cnt !== 16'd5) begin
      errors++;
      $display("FAIL sat_wide: got %0d/%0d want 5/5",
               stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_reset_midwait();
    do_reset();
    repeat (3) begin
      @(negedge clk); idle(); mem_req = 1'b1;
    end
    @(negedge clk); reset = 1'b1; #1;
    checks++;
    if (ctl !== C_MEM) begin
      errors++; $display("FAIL rmw_ctl: got %b want %b", ctl, C_MEM);
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if (dut_s.state_q !== RUN) begin
      errors++; $display("FAIL rmw_state: got %b want RUN", dut_s.state_q);
    end
    checks++;
    if (stall_cnt !== 16'd0 || stall_cnt_s !== 2'd0
        || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rmw_cnt: got %0d/%0d/%0d want 0/0/0",
               stall_cnt, stall_cnt_s, flush_cnt);
    end
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) begin
        @(negedge clk); #1;
      end
      checks++;
      if (mem_timeout_s !== (i >= 5)) begin
        errors++;
        $display("FAIL rmw_wait c%0d: got %b want %b",
                 i, mem_timeout_s, (i >= 5));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp [4];
    exp[0] = C_LU; exp[1] = C_RUN; exp[2] = C_LU; exp[3] = C_RUN;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle();
      case (i)
        0: lu5();
        1: begin id_rs1 = 5'd5; id_uses_rs1 = 1'b1; end
        2: begin
          ex_memtoreg = 1'b1; ex_rd = 5'd6;
          id_rs2 = 5'd6; id_uses_rs2 = 1'b1;
        end
        default: begin id_rs2 = 5'd6; id_uses_rs2 = 1'b1; end
      endcase
      #1;
      checks++;
      if (ctl !== exp[i]) begin
        errors++;
        $display("FAIL b2b c%0d: got %b want %b", i, ctl, exp[i]);
      end
    end
    @(negedge clk); idle(); #1;
    checks++;
    if (stall_cnt !== 16'd2) begin
      errors++; $display("FAIL b2b_cnt: got %0d want 2", stall_cnt);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_x0();
    test_branch();
    test_mem_wait();
    test_memwait_hazard();
    test_timeout();
    test_saturation();
    test_reset_midwait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
